// File: rtl/move_eval_sequencer.sv
// One-ply search sequencer: clears the move generator, walks every generated move through
// the evaluator and keeps the best score for the side to move. Optional watchdog: MOVE_SEQ_TIMEOUT_EN.
`timescale 1ns/1ps

module move_eval_sequencer #(
    parameter int EVAL_WIDTH     = 32,
    parameter int INDEX_WIDTH    = 8,
    parameter int TIMEOUT_CYCLES = 4096
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   start,
    input  logic                   white_to_move,
    output logic                   clear_moves,
    input  logic                   moves_ready,
    input  logic [INDEX_WIDTH-1:0] move_count,
    output logic [INDEX_WIDTH-1:0] move_index,
    input  logic                   move_ready,
    output logic                   clear_eval,
    input  logic                   eval_valid,
    input  logic [EVAL_WIDTH-1:0]  eval,
    output logic                   busy,
    output logic                   done,
    output logic [INDEX_WIDTH-1:0] best_index,
    output logic [EVAL_WIDTH-1:0]  best_eval,
    output logic                   no_moves,
    output logic                   timeout,
    output logic [2:0]             o_dbg_state
);

    // Handshake: clear_moves / clear_eval are single-cycle requests; moves_ready, move_ready and
    // eval_valid are only honoured in the state waiting for them, so stale levels are harmless.
    typedef enum logic [2:0] {
        S_IDLE       = 3'd0,
        S_CLEAR      = 3'd1,
        S_WAIT_MOVES = 3'd2,
        S_SELECT     = 3'd3,
        S_WAIT_MOVE  = 3'd4,
        S_WAIT_EVAL  = 3'd5,
        S_NEXT       = 3'd6,
        S_FINISH     = 3'd7
    } state_t;

    localparam logic [INDEX_WIDTH-1:0] IDX_ONE = INDEX_WIDTH'(1);

    state_t                   r_state;
    state_t                   w_state_next;
    logic                     r_white;
    logic [INDEX_WIDTH-1:0]   r_count;
    logic [INDEX_WIDTH-1:0]   r_move_index;
    logic [INDEX_WIDTH-1:0]   r_best_index;
    logic [EVAL_WIDTH-1:0]    r_best_eval;
    logic                     r_no_moves;
    logic                     w_last;
    logic                     w_better;
    logic                     w_wd_expire;

    assign w_last = (r_move_index == (r_count - IDX_ONE));

    // Index 0 always seeds the best; later moves must be strictly better so ties keep the lower index.
    always_comb begin
        w_better = 1'b0;
        if (r_move_index == '0) begin
            w_better = 1'b1;
        end else if (r_white) begin
            w_better = ($signed(eval) > $signed(r_best_eval));
        end else begin
            w_better = ($signed(eval) < $signed(r_best_eval));
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE: begin
                if (start) begin
                    w_state_next = S_CLEAR;
                end
            end
            S_CLEAR: begin
                w_state_next = S_WAIT_MOVES;
            end
            S_WAIT_MOVES: begin
                if (moves_ready) begin
                    w_state_next = (move_count == '0) ? S_FINISH : S_SELECT;
                end else if (w_wd_expire) begin
                    w_state_next = S_FINISH;
                end
            end
            S_SELECT: begin
                w_state_next = S_WAIT_MOVE;
            end
            S_WAIT_MOVE: begin
                if (move_ready) begin
                    w_state_next = S_WAIT_EVAL;
                end else if (w_wd_expire) begin
                    w_state_next = S_FINISH;
                end
            end
            S_WAIT_EVAL: begin
                if (eval_valid) begin
                    w_state_next = S_NEXT;
                end else if (w_wd_expire) begin
                    w_state_next = S_FINISH;
                end
            end
            S_NEXT: begin
                w_state_next = w_last ? S_FINISH : S_SELECT;
            end
            S_FINISH: begin
                w_state_next = S_IDLE;
            end
            default: begin
                w_state_next = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_white      <= 1'b0;
            r_count      <= '0;
            r_move_index <= '0;
            r_best_index <= '0;
            r_best_eval  <= '0;
            r_no_moves   <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_white    <= white_to_move;
                        r_no_moves <= 1'b0;
                    end
                end
                S_WAIT_MOVES: begin
                    if (moves_ready) begin
                        r_count <= move_count;
                        if (move_count == '0) begin
                            r_no_moves   <= 1'b1;
                            r_best_index <= '0;
                            r_best_eval  <= '0;
                        end else begin
                            r_move_index <= '0;
                        end
                    end
                end
                S_WAIT_EVAL: begin
                    if (eval_valid && w_better) begin
                        r_best_index <= r_move_index;
                        r_best_eval  <= eval;
                    end
                end
                S_NEXT: begin
                    if (!w_last) begin
                        r_move_index <= r_move_index + IDX_ONE;
                    end
                end
                default: begin
                end
            endcase
        end
    end

`ifdef MOVE_SEQ_TIMEOUT_EN
    localparam int                WD_W    = $clog2(TIMEOUT_CYCLES) + 1;
    localparam logic [WD_W-1:0]   WD_LAST = WD_W'(TIMEOUT_CYCLES - 1);
    localparam logic [WD_W-1:0]   WD_ONE  = WD_W'(1);

    logic [WD_W-1:0] r_wd_cnt;
    logic            r_timeout;
    logic            w_waiting;
    logic            w_wait_event;

    assign w_waiting    = (r_state == S_WAIT_MOVES) || (r_state == S_WAIT_MOVE) ||
                          (r_state == S_WAIT_EVAL);
    assign w_wait_event = ((r_state == S_WAIT_MOVES) && moves_ready) ||
                          ((r_state == S_WAIT_MOVE)  && move_ready)  ||
                          ((r_state == S_WAIT_EVAL)  && eval_valid);
    assign w_wd_expire  = w_waiting && (r_wd_cnt == WD_LAST);

    // Reloads on every state change so each wait gets the full budget.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_wd_cnt <= '0;
        end else if (w_state_next != r_state) begin
            r_wd_cnt <= '0;
        end else if (w_waiting && !w_wd_expire) begin
            r_wd_cnt <= r_wd_cnt + WD_ONE;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_timeout <= 1'b0;
        end else if ((r_state == S_IDLE) && start) begin
            r_timeout <= 1'b0;
        end else if (w_wd_expire && !w_wait_event) begin
            r_timeout <= 1'b1;
        end
    end

    assign timeout = r_timeout;
`else
    localparam int UNUSED_TIMEOUT_CYCLES = TIMEOUT_CYCLES;

    assign w_wd_expire = 1'b0;
    assign timeout     = 1'b0;
`endif

    assign clear_moves = (r_state == S_CLEAR);
    assign clear_eval  = (r_state == S_SELECT);
    assign done        = (r_state == S_FINISH);
    assign busy        = (r_state != S_IDLE) && (r_state != S_FINISH);
    assign move_index  = r_move_index;
    assign best_index  = r_best_index;
    assign best_eval   = r_best_eval;
    assign no_moves    = r_no_moves;
    assign o_dbg_state = r_state;

endmodule

// File: tb/tb_move_eval_sequencer.sv
// Directed bench for move_eval_sequencer: responder models for generator/evaluator and a
// result scoreboard checked on every done pulse.
`timescale 1ns/1ps

module tb_move_eval_sequencer;
  localparam int EW = 32;
  localparam int IW = 8;
  localparam int RW = IW + EW + 2;

  logic          clk = 1'b0;
  logic          reset;
  logic          start;
  logic          white_to_move;
  logic          clear_moves;
  logic          moves_ready = 1'b0;
  logic [IW-1:0] move_count;
  logic [IW-1:0] move_index;
  logic          move_ready = 1'b0;
  logic          clear_eval;
  logic          eval_valid = 1'b0;
  logic [EW-1:0] eval = '0;
  logic          busy;
  logic          done;
  logic [IW-1:0] best_index;
  logic [EW-1:0] best_eval;
  logic          no_moves;
  logic          timeout;
  logic [2:0]    o_dbg_state;

  always #5 clk = ~clk;

  move_eval_sequencer #(
    .EVAL_WIDTH    (EW),
    .INDEX_WIDTH   (IW),
    .TIMEOUT_CYCLES(16)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .start        (start),
    .white_to_move(white_to_move),
    .clear_moves  (clear_moves),
    .moves_ready  (moves_ready),
    .move_count   (move_count),
    .move_index   (move_index),
    .move_ready   (move_ready),
    .clear_eval   (clear_eval),
    .eval_valid   (eval_valid),
    .eval         (eval),
    .busy         (busy),
    .done         (done),
    .best_index   (best_index),
    .best_eval    (best_eval),
    .no_moves     (no_moves),
    .timeout      (timeout),
    .o_dbg_state  (o_dbg_state)
  );

  int n_checks = 0;
  int n_pass   = 0;
  logic [RW-1:0] exp_q[$];

  logic [EW-1:0] ev_tab[256];
  int gen_delay = 0;
  int mr_delay  = 0;
  int ev_delay  = 0;
  int hold_idx  = -1;
  int gen_cnt   = 0;
  int mr_cnt    = 0;
  int ev_cnt    = 0;
  logic gen_armed = 1'b0;
  logic ev_armed  = 1'b0;

  int ce_cnt   = 0;
  int done_cnt = 0;
  int idx_wr   = 0;
  logic [IW-1:0] idx_log[256];

  // Generator / evaluator responders: levels drop on each clear and rise after a delay.
  always @(negedge clk) begin
    if (reset) begin
      gen_armed = 1'b0;
      ev_armed  = 1'b0;
    end else begin
      if (clear_moves) begin
        gen_armed = 1'b1;
        gen_cnt   = gen_delay;
      end else if (gen_armed && gen_cnt != 0) begin
        gen_cnt--;
      end
      if (clear_eval) begin
        ev_armed = 1'b1;
        mr_cnt   = mr_delay;
        ev_cnt   = mr_delay + ev_delay;
      end else if (ev_armed) begin
        if (mr_cnt != 0) mr_cnt--;
        if (ev_cnt != 0) ev_cnt--;
      end
    end
    moves_ready = gen_armed && (gen_cnt == 0);
    move_ready  = ev_armed && (mr_cnt == 0);
    eval_valid  = ev_armed && (ev_cnt == 0) && (int'(move_index) != hold_idx);
    eval        = ev_tab[move_index];
  end

  always @(negedge clk) begin
    if (clear_eval) begin
      if (idx_wr < 256) idx_log[idx_wr] = move_index;
      idx_wr++;
      ce_cnt++;
    end
    if (done) done_cnt++;
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
  endtask

  function automatic logic [RW-1:0] pack(input int idx, input logic [EW-1:0] ev,
                                         input logic nm, input logic to);
    return {IW'(idx), ev, nm, to};
  endfunction

  function automatic logic [RW-1:0] model(input int n, input logic wtm);
    int bi;
    logic signed [EW-1:0] be;
    logic signed [EW-1:0] v;
    if (n == 0) return pack(0, '0, 1'b1, 1'b0);
    bi = 0;
    be = $signed(ev_tab[0]);
    for (int i = 1; i < n; i++) begin
      v = $signed(ev_tab[i]);
      if (wtm ? (v > be) : (v < be)) begin
        bi = i;
        be = v;
      end
    end
    return pack(bi, be, 1'b0, 1'b0);
  endfunction

  // mode bit0: change inputs mid-search; bit1: start while busy; bit2: start in done cycle.
  task automatic run_search(input string tag, input logic wtm, input int n,
                            input int exp_lat, input int mode);
    int lat;
    logic seen;
    logic busy1;
    logic [RW-1:0] got;
    logic [RW-1:0] exp;
    move_count    = IW'(n);
    white_to_move = wtm;
    start         = 1'b1;
    lat   = 0;
    seen  = 1'b0;
    busy1 = 1'b0;
    while (!seen && lat < 300) begin
      @(negedge clk);
      lat++;
      start = 1'b0;
      if (lat == 1) busy1 = busy;
      if (mode[0] && lat == 6) begin
        move_count    = IW'(n + 3);
        white_to_move = ~wtm;
      end
      if (mode[1] && lat == 4) start = 1'b1;
      if (done) seen = 1'b1;
    end
    chk({tag, ".done_seen"}, 64'(seen), 64'd1);
    chk({tag, ".busy_after_start"}, 64'(busy1), 64'd1);
    if (seen) begin
      chk({tag, ".busy_in_done"}, 64'(busy), 64'd0);
      if (exp_lat >= 0) chk({tag, ".latency"}, 64'(lat), 64'(exp_lat));
      got = {best_index, best_eval, no_moves, timeout};
      exp = (exp_q.size() > 0) ? exp_q.pop_front() : '1;
      chk({tag, ".result"}, 64'(got), 64'(exp));
      if (mode[2]) begin
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
      end
    end
    @(negedge clk);
  endtask

  initial begin
    int snap;
    int k;
    int n;
    logic w;

    for (int i = 0; i < 256; i++) ev_tab[i] = '0;
    reset         = 1'b1;
    start         = 1'b0;
    white_to_move = 1'b0;
    move_count    = '0;
    repeat (3) @(negedge clk);
    chk("reset.outputs",
        64'({clear_moves, clear_eval, busy, done, no_moves, timeout, move_index, best_index}), 64'd0);
    chk("reset.best_eval", 64'(best_eval), 64'd0);
    chk("reset.state", 64'(o_dbg_state), 64'd0);
    reset = 1'b0;
    @(negedge clk);

    // White, ties keep the lower index.
    ev_tab[0] = 5; ev_tab[1] = 12; ev_tab[2] = 12;
    exp_q.push_back(pack(1, 12, 1'b0, 1'b0));
    snap = ce_cnt;
    run_search("white3", 1'b1, 3, 15, 0);
    chk("white3.clear_eval_pulses", 64'(ce_cnt - snap), 64'd3);

    // Zero moves overwrite the previous best with 0.
    exp_q.push_back(pack(0, 0, 1'b1, 1'b0));
    run_search("zero", 1'b1, 0, 3, 0);

    // Black, with move_count and white_to_move disturbed mid-search.
    ev_tab[0] = 0; ev_tab[1] = -7; ev_tab[2] = 3; ev_tab[3] = -20;
    exp_q.push_back(pack(3, -20, 1'b0, 1'b0));
    snap = idx_wr;
    run_search("black4", 1'b0, 4, 19, 1);
    chk("black4.index_steps", 64'(idx_wr - snap), 64'd4);
    for (int i = 0; i < 4; i++) chk("black4.index_seq", 64'(idx_log[snap + i]), 64'(i));

    // Restart attempts while busy and in the done cycle, with slow responders.
    gen_delay = 2; mr_delay = 1; ev_delay = 2;
    ev_tab[0] = -3; ev_tab[1] = 9;
    exp_q.push_back(pack(1, 9, 1'b0, 1'b0));
    snap = done_cnt;
    run_search("restart", 1'b1, 2, -1, 6);
    repeat (10) @(negedge clk);
    chk("restart.done_count", 64'(done_cnt - snap), 64'd1);
    chk("restart.idle_busy", 64'(busy), 64'd0);
    gen_delay = 0; mr_delay = 0; ev_delay = 0;

    // Signed extremes.
    ev_tab[0] = 32'h8000_0000; ev_tab[1] = 32'h7FFF_FFFF;
    exp_q.push_back(pack(1, 32'h7FFF_FFFF, 1'b0, 1'b0));
    run_search("signed_white", 1'b1, 2, 11, 0);
    ev_tab[0] = 32'h7FFF_FFFF; ev_tab[1] = 32'h8000_0000;
    exp_q.push_back(pack(1, 32'h8000_0000, 1'b0, 1'b0));
    run_search("signed_black", 1'b0, 2, 11, 0);

    // Random move lists with a narrow score range so ties are common.
    for (int t = 0; t < 4; t++) begin
      n = $urandom_range(1, 9);
      w = 1'(($urandom_range(0, 1)));
      for (int i = 0; i < n; i++) ev_tab[i] = $urandom_range(0, 8) - 4;
      exp_q.push_back(model(n, w));
      run_search("random", w, n, 3 + 4 * n, 0);
    end

    // Reset while stalled in WAIT_EVAL at index 2.
    ev_tab[0] = 4; ev_tab[1] = 9; ev_tab[2] = 1; ev_tab[3] = 6; ev_tab[4] = 2;
    hold_idx      = 2;
    move_count    = 5;
    white_to_move = 1'b1;
    start         = 1'b1;
    @(negedge clk);
    start = 1'b0;
    k = 0;
    while (!(clear_eval && move_index == 2) && k < 100) begin
      @(negedge clk);
      k++;
    end
    chk("midreset.reached_index2", 64'(k < 100), 64'd1);
    repeat (2) @(negedge clk);
    chk("midreset.in_wait_eval", 64'(o_dbg_state), 64'd5);
    chk("midreset.best_before", 64'({best_index, best_eval}), 64'({8'd1, 32'd9}));
    reset = 1'b1;
    @(negedge clk);
    chk("midreset.outputs",
        64'({clear_moves, clear_eval, busy, done, no_moves, timeout, move_index, best_index}), 64'd0);
    chk("midreset.best_eval", 64'(best_eval), 64'd0);
    chk("midreset.state", 64'(o_dbg_state), 64'd0);
    reset    = 1'b0;
    hold_idx = -1;
    @(negedge clk);
    exp_q.push_back(pack(1, 9, 1'b0, 1'b0));
    run_search("after_reset", 1'b1, 3, 15, 0);

`ifdef MOVE_SEQ_TIMEOUT_EN
    ev_tab[0] = 7; ev_tab[1] = 2; ev_tab[2] = 5;
    hold_idx = 1;
    exp_q.push_back(pack(0, 7, 1'b0, 1'b1));
    run_search("timeout", 1'b1, 3, -1, 0);
    hold_idx = -1;
    exp_q.push_back(pack(1, 9, 1'b0, 1'b0));
    ev_tab[0] = 4; ev_tab[1] = 9;
    run_search("after_timeout", 1'b1, 2, 11, 0);
`endif

    chk("scoreboard.empty", 64'(exp_q.size()), 64'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
